// File: rtl/s4ga_v2.sv
// Serially configured K-input LUT array: records stream in SI_W bits at a time,
// each completed record evaluates one LUT and shifts its result into the state.
module s4ga_v2 #(
    parameter int N     = 64,
    parameter int K     = 4,
    parameter int SI_W  = 4,
    parameter int SYNC  = 0,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SI_W-1:0]  si,
    input  logic             si_valid,
    output logic [OUT_W-1:0] out,
    output logic             lut_valid,
    output logic             frame_done
);
    localparam int IDX_W     = $clog2(N);
    localparam int IDX_SEGS  = (IDX_W + SI_W - 1) / SI_W;
    localparam int MASK_W    = 1 << K;
    localparam int MASK_SEGS = (MASK_W + SI_W - 1) / SI_W;
    localparam int MAXW      = (MASK_W > IDX_W) ? MASK_W : IDX_W;
    localparam int COL_W     = (MAXW > SI_W) ? MAXW : SI_W + 1;
    localparam int SR_W      = COL_W - SI_W;
    localparam int MAX_SEGS  = (MASK_SEGS > IDX_SEGS) ? MASK_SEGS : IDX_SEGS;
    localparam int SEG_W     = $clog2(MAX_SEGS + 1);
    localparam int K_W       = $clog2(K + 1);
    localparam int PAD_W     = 1 << IDX_W;

    localparam logic [SEG_W-1:0] IDX_LAST  = SEG_W'(IDX_SEGS - 1);
    localparam logic [SEG_W-1:0] MASK_LAST = SEG_W'(MASK_SEGS - 1);
    localparam logic [K_W-1:0]   K_MASK    = K_W'(K);
    localparam logic [IDX_W-1:0] N_LAST    = IDX_W'(N - 1);

    logic [SR_W-1:0]   sr;
    logic [COL_W-1:0]  col;
    logic [K-1:0]      in_sr;
    logic [K_W-1:0]    k;
    logic [SEG_W-1:0]  seg;
    logic [IDX_W-1:0]  n;
    logic [N-1:0]      cur;
    logic [PAD_W-1:0]  rd_pad;
    logic [IDX_W-1:0]  idx;
    logic [MASK_W-1:0] mask;
    logic              at_mask;
    logic              last_seg;
    logic              idx_bit;
    logic              result;
    logic              lut_done;
    logic              frame_end;
    logic              unused_col;

    // Field value is always the low bits of {sr, si}; older segments sit above it.
    always_comb begin
        col       = {sr, si};
        at_mask   = (k == K_MASK);
        last_seg  = at_mask ? (seg == MASK_LAST) : (seg == IDX_LAST);
        idx       = col[IDX_W-1:0];
        rd_pad    = PAD_W'(cur);
        idx_bit   = rd_pad[idx];
        mask      = col[MASK_W-1:0];
        result    = mask[in_sr];
        lut_done  = si_valid && at_mask && last_seg;
        frame_end = lut_done && (n == N_LAST);
    end

    assign unused_col = ^col[COL_W-1:SR_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr         <= '0;
            in_sr      <= '0;
            k          <= '0;
            seg        <= '0;
            n          <= '0;
            lut_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            lut_valid  <= lut_done;
            frame_done <= frame_end;
            if (si_valid) begin
                sr <= col[SR_W-1:0];
                if (!last_seg) begin
                    seg <= seg + SEG_W'(1);
                end else begin
                    seg <= '0;
                    if (at_mask) begin
                        k <= '0;
                        n <= frame_end ? '0 : n + IDX_W'(1);
                    end else begin
                        k     <= k + K_W'(1);
                        in_sr <= K'({in_sr, idx_bit});
                    end
                end
            end
        end
    end

    generate
        if (SYNC == 0) begin : g_immediate
            always_ff @(posedge clk) begin
                if (!rst_n)
                    cur <= '0;
                else if (lut_done)
                    cur <= {cur[N-2:0], result};
            end
        end else begin : g_double
            logic [N-1:0] nxt;
            logic         unused_nxt;

            assign unused_nxt = nxt[N-1];

            // Commit includes the final LUT's result in the same edge.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    nxt <= '0;
                    cur <= '0;
                end else if (lut_done) begin
                    nxt <= {nxt[N-2:0], result};
                    if (frame_end)
                        cur <= {nxt[N-2:0], result};
                end
            end
        end
    endgenerate

    assign out = cur[OUT_W-1:0];

endmodule

// File: tb/tb_s4ga_v2.sv
// Bench for s4ga_v2: one shared stream drives three configurations, checked by a
// reference model scoreboard, a hand-computed vector table and corner sequences.
module tb_s4ga_v2;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] si;
    logic       si_valid;
    logic [7:0] out0, out1, out2;
    logic       lv0, lv1, lv2, fd0, fd1, fd2;

    always #5 clk = ~clk;

    s4ga_v2 #(.N(16), .K(4), .SI_W(4), .SYNC(0), .OUT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .si(si), .si_valid(si_valid),
        .out(out0), .lut_valid(lv0), .frame_done(fd0));
    s4ga_v2 #(.N(16), .K(4), .SI_W(4), .SYNC(1), .OUT_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .si(si), .si_valid(si_valid),
        .out(out1), .lut_valid(lv1), .frame_done(fd1));
    s4ga_v2 #(.N(12), .K(4), .SI_W(4), .SYNC(0), .OUT_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .si(si), .si_valid(si_valid),
        .out(out2), .lut_valid(lv2), .frame_done(fd2));

    typedef struct packed {
        logic [7:0] out;
        logic       fd;
    } sb_t;

    typedef struct {
        logic [15:0] idx;
        logic [15:0] mask;
        bit          stall;
        logic [7:0]  exp;
    } vec_t;

    localparam int MN[3] = '{16, 16, 12};
    localparam int MS[3] = '{0, 1, 0};

    sb_t         q0[$], q1[$], q2[$];
    logic [15:0] m_cur[3];
    logic [15:0] m_nxt[3];
    int          m_n[3];
    int          n_vec = 0;
    int          n_err = 0;
    vec_t        tbl[8];

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_push(input logic [15:0] idx, input logic [15:0] mask);
        for (int d = 0; d < 3; d++) begin
            logic [3:0]  sel;
            logic        r;
            logic [15:0] keep;
            sb_t         e;
            keep = (MN[d] == 16) ? 16'hFFFF : 16'h0FFF;
            for (int j = 0; j < 4; j++) begin
                int ix;
                ix = int'(idx[15-4*j -: 4]);
                sel[3-j] = (ix < MN[d]) ? m_cur[d][ix] : 1'b0;
            end
            r = mask[sel];
            e.fd = (m_n[d] == MN[d] - 1);
            if (MS[d] == 0) begin
                m_cur[d] = ((m_cur[d] << 1) | {15'd0, r}) & keep;
            end else begin
                m_nxt[d] = ((m_nxt[d] << 1) | {15'd0, r}) & keep;
                if (e.fd) m_cur[d] = m_nxt[d];
            end
            m_n[d] = e.fd ? 0 : m_n[d] + 1;
            e.out = m_cur[d][7:0];
            case (d)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    task automatic sb_check(input int d, input logic lv, input logic fd, input logic [7:0] o);
        sb_t e;
        int  sz;
        sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
        if (lv === 1'b1) begin
            n_vec++;
            if (sz == 0) begin
                n_err++;
                $display("FAIL stray_lut_valid dut%0d: got lut_valid=1 expected 0", d);
            end else begin
                case (d)
                    0:       e = q0.pop_front();
                    1:       e = q1.pop_front();
                    default: e = q2.pop_front();
                endcase
                if (o !== e.out || fd !== e.fd) begin
                    n_err++;
                    $display("FAIL sb_dut%0d: got out=%h frame_done=%b expected out=%h frame_done=%b",
                             d, o, fd, e.out, e.fd);
                end
            end
        end else if (lv !== 1'b0 || fd !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_pulses dut%0d: got lut_valid=%b frame_done=%b expected 0 0", d, lv, fd);
        end
    endtask

    always @(negedge clk) begin
        #1;
        sb_check(0, lv0, fd0, out0);
        sb_check(1, lv1, fd1, out1);
        sb_check(2, lv2, fd2, out2);
    end

    task automatic do_reset();
        si_valid = 1'b0;
        @(negedge clk);
        rst_n    = 1'b0;
        si_valid = 1'b1;
        for (int d = 0; d < 3; d++) begin
            m_cur[d] = '0;
            m_nxt[d] = '0;
            m_n[d]   = 0;
        end
        q0.delete();
        q1.delete();
        q2.delete();
        repeat (2) begin
            si = 4'($urandom);
            @(negedge clk);
        end
        rst_n    = 1'b1;
        si_valid = 1'b0;
    endtask

    task automatic drive_seg(input logic [3:0] v, input bit stall);
        if (stall) begin
            si_valid = 1'b0;
            si       = 4'($urandom);
            @(negedge clk);
        end
        si       = v;
        si_valid = 1'b1;
        @(negedge clk);
    endtask

    // Returns at the falling edge right after the record's final segment was taken.
    task automatic send_record(input logic [15:0] idx, input logic [15:0] mask, input bit stall);
        for (int j = 0; j < 4; j++) drive_seg(idx[15-4*j -: 4], stall);
        for (int j = 0; j < 4; j++) drive_seg(mask[15-4*j -: 4], stall);
        si_valid = 1'b0;
        model_push(idx, mask);
    endtask

    initial begin
        rst_n    = 1'b1;
        si       = '0;
        si_valid = 1'b0;

        tbl[0] = '{16'h0000, 16'hFFFF, 1'b0, 8'h01};
        tbl[1] = '{16'h0000, 16'hAAAA, 1'b0, 8'h03};
        tbl[2] = '{16'h0123, 16'h1000, 1'b0, 8'h07};
        tbl[3] = '{16'hFFFF, 16'h0001, 1'b0, 8'h0F};
        tbl[4] = '{16'h3210, 16'h8000, 1'b1, 8'h1F};
        tbl[5] = '{16'h0000, 16'h5555, 1'b1, 8'h3E};
        tbl[6] = '{16'h0123, 16'h00F0, 1'b0, 8'h7D};
        tbl[7] = '{16'h5555, 16'h8001, 1'b0, 8'hFB};

        // Reset with live stream
        do_reset();
        chk("reset_out0", out0, 8'h00);
        chk("reset_out1", out1, 8'h00);
        chk("reset_out2", out2, 8'h00);
        chk("reset_lut_valid", {7'd0, lv0}, 8'h00);
        chk("reset_frame_done", {7'd0, fd0}, 8'h00);

        // Single LUT timing, then its successor
        send_record(16'h0000, 16'hFFFF, 1'b0);
        chk("lut_valid_edge8", {7'd0, lv0}, 8'h01);
        chk("single_lut_out", out0, 8'h01);
        @(negedge clk);
        chk("lut_valid_one_cycle", {7'd0, lv0}, 8'h00);
        send_record(16'h0000, 16'hAAAA, 1'b0);
        chk("second_lut_out", out0, 8'h03);

        // Same records with a stall before every segment
        do_reset();
        send_record(16'h0000, 16'hFFFF, 1'b1);
        chk("stall_lut_valid_edge16", {7'd0, lv0}, 8'h01);
        chk("stall_out_first", out0, 8'h01);
        send_record(16'h0000, 16'hAAAA, 1'b1);
        chk("stall_out_second", out0, 8'h03);

        // Table of hand-evaluated records (immediate mode, N=16)
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send_record(tbl[i].idx, tbl[i].mask, tbl[i].stall);
            chk($sformatf("table_%0d", i), out0, tbl[i].exp);
        end

        // Double-buffered visibility over two frames
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 16; r++) begin
                if (r == 0 || r == 15) send_record(16'h0000, 16'hFFFF, 1'b0);
                else                   send_record(16'hFFFF, 16'hAAAA, 1'b0);
                if (r == 7)
                    chk($sformatf("sync_midframe_%0d", f), out1, (f == 0) ? 8'h00 : 8'h01);
            end
            chk($sformatf("sync_frame_done_%0d", f), {7'd0, fd1}, 8'h01);
            chk($sformatf("sync_frame_out_%0d", f), out1, (f == 0) ? 8'h01 : 8'hFF);
        end

        // Reset in the middle of a record
        do_reset();
        for (int j = 0; j < 5; j++) drive_seg(4'hF, 1'b0);
        do_reset();
        send_record(16'h0000, 16'hFFFF, 1'b0);
        chk("midrec_lut_valid", {7'd0, lv0}, 8'h01);
        chk("midrec_out0", out0, 8'h01);
        chk("midrec_out2", out2, 8'h01);

        // Non-power-of-two N: out-of-range indices and frame wrap
        do_reset();
        send_record(16'hFFFF, 16'h0001, 1'b0);
        chk("n12_oob_index", out2, 8'h01);
        for (int r = 1; r < 12; r++) begin
            send_record(16'h0000, 16'hAAAA, 1'b0);
            if (r == 10) chk("n12_no_early_frame_done", {7'd0, fd2}, 8'h00);
        end
        chk("n12_frame_done", {7'd0, fd2}, 8'h01);
        send_record(16'h0000, 16'h0000, 1'b0);
        chk("n12_wrap_no_frame_done", {7'd0, fd2}, 8'h00);

        // Random records with random stalls, checked by the scoreboard
        for (int r = 0; r < 40; r++)
            send_record(16'($urandom), 16'($urandom), bit'($urandom_range(0, 1)));

        @(negedge clk);
        @(negedge clk);
        chk("sb_drained_0", 8'(q0.size()), 8'h00);
        chk("sb_drained_1", 8'(q1.size()), 8'h00);
        chk("sb_drained_2", 8'(q2.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
